pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed-field stage registers.
- One generic pipeline stage carries a DATA_W-bit payload with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Synchronous flush injects a bubble.
- Per-lane forwarding updates the held payload while the stage is stalled.
- A saturating hold-cycle counter supports hazard and performance debug.
- Sits between any two pipeline stages (IF/ID ... MEM/WB) and replaces the per-stage stall/flush register sets.

---
 rtl/pipe_stage_elastic.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// Generic elastic pipeline stage. It carries a DATA_W-bit payload with a
// valid/ready handshake and uses a 2-entry skid buffer, so the stage keeps
// full throughput while in_ready stays a flop output. A synchronous flush
// kills the held contents. Per-lane forwarding patches the payload held in
// the main register while the stage is stalled. A saturating counter reports
// how many consecutive cycles the output has been held.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous kill; loads FLUSH_WORD and empties the stage
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (registered, equals ~skid_valid)
//   in_data    in   upstream payload, DATA_W bits
//   out_valid  out  downstream payload valid (main register)
//   out_ready  in   downstream accepts
//   out_data   out  payload from the main register, DATA_W bits
//   fwd_en     in   per-lane forward enable, LANES bits
//   fwd_value  in   forwarded lane values, lane i at [i*LANE_W +: LANE_W]
//   hold_cnt   out  consecutive out_valid & ~out_ready cycles, saturating
module pipe_stage_elastic #(
    parameter int                 DATA_W     = 48,
    parameter int                 LANES      = 2,
    parameter int                 LANE_W     = 16,
    parameter int                 LANE_BASE  = 16,
    parameter logic [DATA_W-1:0]  FLUSH_WORD = '0,
    parameter int                 CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    input  logic [LANES-1:0]          fwd_en,
    input  logic [LANES*LANE_W-1:0]   fwd_value,
    output logic [CNT_W-1:0]          hold_cnt
);

    // The lane map must fit inside the payload.
    if (LANE_BASE + LANES * LANE_W > DATA_W) begin : g_lane_check
        $error("pipe_stage_elastic: lanes exceed DATA_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  hold_cnt_q,   hold_cnt_d;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = main_valid_q & out_ready;

    // Next-state logic: flush, then refill of a free main register, then stall handling.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        hold_cnt_d   = hold_cnt_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = FLUSH_WORD;
            skid_valid_d = 1'b0;
            skid_data_d  = FLUSH_WORD;
            hold_cnt_d   = CNT_ZERO;
        end else if (!main_valid_q || out_fire_s) begin
            // Main is free: the skid entry is older than anything arriving now.
            hold_cnt_d = CNT_ZERO;
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                // Bubble: payload bits are kept, only valid drops.
                main_valid_d = 1'b0;
            end
        end else begin
            // Main is held: park new input in the skid slot, patch main lanes.
            if (in_fire_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
            for (int i = 0; i < LANES; i++) begin
                if (fwd_en[i]) begin
                    main_data_d[LANE_BASE + i*LANE_W +: LANE_W] = fwd_value[i*LANE_W +: LANE_W];
                end else begin
                    main_data_d[LANE_BASE + i*LANE_W +: LANE_W] = main_data_q[LANE_BASE + i*LANE_W +: LANE_W];
                end
            end
            if (hold_cnt_q == CNT_MAX) begin
                hold_cnt_d = CNT_MAX;
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
        end
        // in_ready is the registered complement of the next skid occupancy.
        in_ready_d = ~skid_valid_d;
    end

    // State registers with asynchronous reset to the flush values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= FLUSH_WORD;
            skid_valid_q <= 1'b0;
            skid_data_q  <= FLUSH_WORD;
            in_ready_q   <= 1'b1;
            hold_cnt_q   <= CNT_ZERO;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign in_ready  = in_ready_q;
    assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios with literal
// expectations plus a randomized run checked each cycle against a queue model.
module tb_pipe_stage_elastic;

    localparam int          DW  = 48;
    localparam int          LN  = 2;
    localparam int          LW  = 16;
    localparam int          LB  = 16;
    localparam int          CW  = 3;
    localparam logic [47:0] FW  = 48'hDEAD_0000_BEEF;
    localparam int          CMAX = 7;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [LN-1:0]    fwd_en;
    logic [LN*LW-1:0] fwd_value;
    logic [CW-1:0]    hold_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: ordered contents of the stage, the visible payload, hold count.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data;
    int            m_cnt;

    pipe_stage_elastic #(
        .DATA_W(DW), .LANES(LN), .LANE_W(LW), .LANE_BASE(LB),
        .FLUSH_WORD(FW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fwd_en(fwd_en), .fwd_value(fwd_value), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model: a FIFO of at most two entries.
    task automatic model_step();
        logic held, ofire, ifire;
        logic [DW-1:0] tmp;
        if (!reset_n || flush) begin
            mq.delete();
            m_data = FW;
            m_cnt  = 0;
        end else begin
            held  = (mq.size() > 0) && !out_ready;
            ofire = (mq.size() > 0) && out_ready;
            ifire = in_valid && (mq.size() < 2);
            if (held) begin
                tmp = mq[0];
                for (int i = 0; i < LN; i++)
                    if (fwd_en[i]) tmp[LB + i*LW +: LW] = fwd_value[i*LW +: LW];
                mq[0] = tmp;
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            end else begin
                m_cnt = 0;
            end
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
            if (mq.size() > 0) m_data = mq[0];
        end
    endtask

    // Compare process: advance the model on every edge and check all outputs.
    initial begin
        m_data = FW;
        m_cnt  = 0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("m_out_data",  64'(out_data),  64'(m_data));
            chk("m_in_ready",  64'(in_ready),  64'(mq.size() < 2));
            chk("m_hold_cnt",  64'(hold_cnt),  64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        logic [63:0] r64;
        int          bias;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; fwd_en = '0; fwd_value = '0;

        // Reset state.
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'(FW));
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_hold_cnt",  64'(hold_cnt),  64'd0);
        reset_n = 1'b1;

        // Stream 1,2,3 with out_ready=1: one-cycle latency, no bubbles.
        drive(1'b1, 48'h1, 1'b1); step();
        chk("str_d1", 64'(out_data), 64'h1); chk("str_v1", 64'(out_valid), 64'd1);
        drive(1'b1, 48'h2, 1'b1); step();
        chk("str_d2", 64'(out_data), 64'h2); chk("str_r2", 64'(in_ready), 64'd1);
        drive(1'b1, 48'h3, 1'b1); step();
        chk("str_d3", 64'(out_data), 64'h3); chk("str_r3", 64'(in_ready), 64'd1);
        drive(1'b0, 48'h0, 1'b1); step();
        chk("str_empty_v", 64'(out_valid), 64'd0);
        chk("str_keep_d",  64'(out_data),  64'h3);

        // Backpressure and skid ordering.
        drive(1'b1, 48'hA, 1'b0); step();
        chk("bp_dA", 64'(out_data), 64'hA); chk("bp_cnt0", 64'(hold_cnt), 64'd0);
        drive(1'b1, 48'hB, 1'b0); step();
        chk("bp_hold_A", 64'(out_data), 64'hA); chk("bp_rdy0", 64'(in_ready), 64'd0);
        chk("bp_cnt1", 64'(hold_cnt), 64'd1);
        drive(1'b0, 48'h0, 1'b0); step();
        chk("bp_cnt2", 64'(hold_cnt), 64'd2);
        step();
        chk("bp_cnt3", 64'(hold_cnt), 64'd3);
        drive(1'b0, 48'h0, 1'b1); step();
        chk("bp_dB", 64'(out_data), 64'hB); chk("bp_rdy1", 64'(in_ready), 64'd1);
        chk("bp_cnt_clr", 64'(hold_cnt), 64'd0);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Counter saturation at 2^3-1.
        drive(1'b1, 48'h5, 1'b0); step();
        drive(1'b0, 48'h0, 1'b0);
        repeat (10) step();
        chk("sat_cnt7", 64'(hold_cnt), 64'd7);
        drive(1'b0, 48'h0, 1'b1); step();
        chk("sat_clr", 64'(hold_cnt), 64'd0);

        // Forward while held: only lane 1 (bits 47:32) changes.
        drive(1'b1, 48'h0000_1111_2222, 1'b0); step();
        drive(1'b0, 48'h0, 1'b0);
        fwd_en = 2'b10; fwd_value = {16'h7777, 16'h9999}; step();
        chk("fwd_lane1", 64'(out_data), 64'h7777_1111_2222);
        fwd_en = 2'b01; out_ready = 1'b1; step();
        chk("fwd_ignored", 64'(out_data), 64'h7777_1111_2222);
        chk("fwd_out_v", 64'(out_valid), 64'd0);
        fwd_en = '0;

        // Flush with both entries full, plus input and forwarding.
        drive(1'b1, 48'h11, 1'b0); step();
        drive(1'b1, 48'h22, 1'b0); step();
        drive(1'b1, 48'h33, 1'b0); flush = 1'b1; fwd_en = 2'b11; step();
        chk("fl_v",   64'(out_valid), 64'd0);
        chk("fl_d",   64'(out_data),  64'(FW));
        chk("fl_rdy", 64'(in_ready),  64'd1);
        chk("fl_cnt", 64'(hold_cnt),  64'd0);
        flush = 1'b0; fwd_en = '0; drive(1'b0, 48'h0, 1'b1); step();
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stall with skid full.
        drive(1'b1, 48'h44, 1'b0); step();
        drive(1'b1, 48'h55, 1'b0); step();
        chk("ar_pre_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_v",   64'(out_valid), 64'd0);
        chk("ar_rdy", 64'(in_ready),  64'd1);
        chk("ar_d",   64'(out_data),  64'(FW));
        step(); step();
        reset_n = 1'b1;

        // Randomized traffic with varying backpressure, forwarding and flushes.
        bias = 0;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) bias = int'($urandom_range(0, 3));
            r64       = {$urandom(), $urandom()};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = r64[DW-1:0];
            out_ready = (int'($urandom_range(0, 3)) >= bias);
            fwd_en    = LN'($urandom_range(0, 3));
            fwd_value = LN*LW'($urandom());
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
